lagarto_pipe_ctrl: RTL

- Central stall/flush sequencer for the in-order pipeline.
- Drives the lock and FLUSH inputs of the IF/ID, ID/EXE and EXE/WB latches.
- Holds the pipeline during data-memory misses and multicycle EXE ops. Issues flush-plus-PC-redirect sequences for WB exceptions and taken EXE branches.
- Sits beside the latches in the core top level; it is the only source of their lock/FLUSH.

---
 rtl/lagarto_ctrl_pkg.sv | 32 +++
 rtl/lagarto_ctrl_counter.sv | 41 ++++
 rtl/lagarto_pipe_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lagarto_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lagarto_ctrl_pkg
// Purpose  : Shared types and constants for the Lagarto pipeline stall/flush
//            sequencer (state encoding, redirect cause, default widths).
// Revision : 1.0 - initial release
// ============================================================================
package lagarto_ctrl_pkg;

  // Default PC / redirect address width of the core.
  localparam int unsigned LAGARTO_ADDR_W = 40;

  // Width of the debug state encoding.
  localparam int unsigned CTRL_STATE_W = 3;

  // Sequencer states; encodings are visible on the debug port.
  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_MC_WAIT  = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_ERR      = 3'd4
  } ctrl_state_e;

  // Why a redirect was started; selects the address that gets latched.
  typedef enum logic {
    CAUSE_XCPT   = 1'b0,
    CAUSE_BRANCH = 1'b1
  } redir_cause_e;

endpackage
`default_nettype wire

// File: rtl/lagarto_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module   : lagarto_ctrl_counter
// Purpose  : Saturating cycle counter with clear, increment and terminal
//            compare. Shared by the flush-duration and dmem-watchdog timing.
//            clr has priority; clr together with inc loads 1, so a wait can
//            start counting in its entry cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lagarto_ctrl_counter
  import lagarto_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  logic saturated;

  assign saturated = &count;
  assign at_term   = (count == term);

  // Counter register: clear (optionally restarting at 1), else saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && !saturated) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lagarto_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lagarto_pipe_ctrl
// Purpose  : Central stall/flush sequencer of the in-order pipeline. Drives
//            lock and flush of the IF/ID, ID/EXE and EXE/WB latches, holds the
//            pipe on dmem misses and multicycle ops, and issues flush plus
//            PC-redirect sequences for WB exceptions and taken EXE branches.
// Revision : 1.0 - initial release
// ============================================================================
module lagarto_pipe_ctrl
  import lagarto_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = LAGARTO_ADDR_W,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DMEM_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EXE_VALID,
  input  logic                    EXE_DMEM_REQ,
  input  logic                    DMEM_RESP_VALID,
  input  logic                    EXE_MC_BUSY,
  input  logic                    EXE_BRANCH_TAKEN,
  input  logic [ADDR_W-1:0]       EXE_BRANCH_TARGET,
  input  logic                    WB_XCPT,
  input  logic [ADDR_W-1:0]       XCPT_VECTOR,
  output logic                    LOCK_IF_ID,
  output logic                    LOCK_ID_EXE,
  output logic                    LOCK_EXE_WB,
  output logic                    FLUSH_IF_ID,
  output logic                    FLUSH_ID_EXE,
  output logic                    FLUSH_EXE_WB,
  output logic                    PC_REDIRECT_VALID,
  output logic [ADDR_W-1:0]       PC_REDIRECT_ADDR,
  output logic                    DMEM_KILL,
  output logic                    DMEM_TIMEOUT_ERR,
  output logic [CTRL_STATE_W-1:0] CTRL_STATE
);

  // Terminal counts: REDIRECT lasts FLUSH_CYCLES cycles starting from count 0;
  // MEM_WAIT starts at count 1, so the watchdog fires in wait cycle DMEM_TIMEOUT.
  localparam logic [CNT_W-1:0] FLUSH_TERM = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DMEM_TERM  = CNT_W'(DMEM_TIMEOUT);

  ctrl_state_e        state;
  ctrl_state_e        next_state;
  redir_cause_e       redir_cause;
  logic               take_xcpt;
  logic               take_branch;
  logic               mem_miss;
  logic               mc_stall;
  logic               lock;
  logic               flush;
  logic               redirect_event;
  logic               cnt_clr;
  logic               cnt_inc;
  logic [CNT_W-1:0]   cnt_term;
  logic [CNT_W-1:0]   cnt_value;
  logic               cnt_at_term;
  logic [ADDR_W-1:0]  redir_addr;
  logic               redirect_valid;
  logic               dmem_kill;
  logic               timeout_err;

  // Event decode shared by RUN / MEM_WAIT / MC_WAIT (priority applied in the FSM).
  assign take_xcpt   = WB_XCPT;
  assign take_branch = EXE_VALID & EXE_BRANCH_TAKEN;
  assign mem_miss    = EXE_VALID & EXE_DMEM_REQ & ~DMEM_RESP_VALID;
  assign mc_stall    = EXE_VALID & EXE_MC_BUSY;

  lagarto_ctrl_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (CLK),
    .rst     (RST),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .count   (cnt_value),
    .at_term (cnt_at_term)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, lock and counter control; a redirect event releases locks at once.
  always_comb begin
    next_state  = state;
    lock        = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cnt_term    = DMEM_TERM;
    redir_cause = take_xcpt ? CAUSE_XCPT : CAUSE_BRANCH;

    case (state)
      ST_RUN: begin
        cnt_clr = 1'b1;
        if (take_xcpt || take_branch) begin
          next_state = ST_REDIRECT;
        end else if (mem_miss) begin
          lock       = 1'b1;
          cnt_inc    = 1'b1;
          next_state = ST_MEM_WAIT;
        end else if (mc_stall) begin
          lock       = 1'b1;
          next_state = ST_MC_WAIT;
        end
      end

      ST_MEM_WAIT: begin
        if (take_xcpt || take_branch) begin
          cnt_clr    = 1'b1;
          next_state = ST_REDIRECT;
        end else if (DMEM_RESP_VALID) begin
          cnt_clr    = 1'b1;
          next_state = ST_RUN;
        end else begin
          lock = 1'b1;
          if (cnt_at_term) begin
            next_state = ST_ERR;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_MC_WAIT: begin
        cnt_clr = 1'b1;
        if (take_xcpt || take_branch) begin
          next_state = ST_REDIRECT;
        end else if (!EXE_MC_BUSY) begin
          next_state = ST_RUN;
        end else begin
          lock = 1'b1;
        end
      end

      ST_REDIRECT: begin
        // Wrong-path exceptions/branches are ignored while flushing.
        cnt_term = FLUSH_TERM;
        if (cnt_at_term) begin
          cnt_clr    = 1'b1;
          next_state = ST_RUN;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      ST_ERR: begin
        lock = 1'b1;
      end

      default: begin
        cnt_clr    = 1'b1;
        next_state = ST_RUN;
      end
    endcase
  end

  assign redirect_event = (next_state == ST_REDIRECT) && (state != ST_REDIRECT);
  assign flush          = (state == ST_REDIRECT);

  // Redirect pulse, target latch, dmem kill pulse and sticky watchdog error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      redirect_valid <= 1'b0;
      redir_addr     <= '0;
      dmem_kill      <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      redirect_valid <= redirect_event;
      dmem_kill      <= redirect_event && (state == ST_MEM_WAIT);
      timeout_err    <= timeout_err | (next_state == ST_ERR);
      if (redirect_event) begin
        redir_addr <= (redir_cause == CAUSE_XCPT) ? XCPT_VECTOR : EXE_BRANCH_TARGET;
      end
    end
  end

  // Latches favour lock over flush, so lock is masked whenever flush is active.
  assign LOCK_IF_ID        = lock & ~flush;
  assign LOCK_ID_EXE       = lock & ~flush;
  assign LOCK_EXE_WB       = lock & ~flush;
  assign FLUSH_IF_ID       = flush;
  assign FLUSH_ID_EXE      = flush;
  assign FLUSH_EXE_WB      = flush;
  assign PC_REDIRECT_VALID = redirect_valid;
  assign PC_REDIRECT_ADDR  = redir_addr;
  assign DMEM_KILL         = dmem_kill;
  assign DMEM_TIMEOUT_ERR  = timeout_err;
  assign CTRL_STATE        = state;

endmodule
`default_nettype wire
